// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: one-hot op bit positions, branch-unit mask,
// FSM states and memory access sizes.
package exec_pkg;

    localparam int OP_BITS = 37;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_XOR   = 2;
    localparam int OP_OR    = 3;
    localparam int OP_AND   = 4;
    localparam int OP_SLL   = 5;
    localparam int OP_SRL   = 6;
    localparam int OP_SRA   = 7;
    localparam int OP_SLT   = 8;
    localparam int OP_SLTU  = 9;
    localparam int OP_ADDI  = 10;
    localparam int OP_XORI  = 11;
    localparam int OP_ORI   = 12;
    localparam int OP_ANDI  = 13;
    localparam int OP_SLLI  = 14;
    localparam int OP_SRLI  = 15;
    localparam int OP_SRAI  = 16;
    localparam int OP_SLTI  = 17;
    localparam int OP_SLTIU = 18;
    localparam int OP_LB    = 19;
    localparam int OP_LH    = 20;
    localparam int OP_LW    = 21;
    localparam int OP_LBU   = 22;
    localparam int OP_LHU   = 23;
    localparam int OP_SB    = 24;
    localparam int OP_SH    = 25;
    localparam int OP_SW    = 26;
    localparam int OP_LUI   = 35;
    localparam int OP_AUIPC = 36;

    // Bits 27..34 are owned by the branch unit and are illegal here.
    localparam logic [OP_BITS-1:0] ILLEGAL_MASK = 37'h7F8000000;

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

endpackage

// File: rtl/lsu_lane.sv
// Combinational load/store lane logic: byte enables, replicated store data,
// misalignment check and load extraction with sign/zero extension.
module lsu_lane
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN/8),
    localparam int BE_W = XLEN/8
) (
    input  mem_size_t         i_size,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [XLEN-1:0]   i_rs2,
    output logic [BE_W-1:0]   o_be,
    output logic [XLEN-1:0]   o_wdata,
    output logic              o_misaligned,
    input  mem_size_t         i_ld_size,
    input  logic              i_ld_signed,
    input  logic [OFF_W-1:0]  i_ld_off,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [XLEN-1:0]   o_ld_data
);

    logic [BE_W-1:0] w_be_mask;
    logic [XLEN-1:0] w_ld_shift;

    always_comb begin
        w_be_mask = BE_W'(4'b1111);
        o_wdata   = {(XLEN/32){i_rs2[31:0]}};
        case (i_size)
            SZ_B: begin
                w_be_mask = BE_W'(1);
                o_wdata   = {BE_W{i_rs2[7:0]}};
            end
            SZ_H: begin
                w_be_mask = BE_W'(2'b11);
                o_wdata   = {(XLEN/16){i_rs2[15:0]}};
            end
            default: ;
        endcase
    end

    assign o_be         = w_be_mask << i_off;
    assign o_misaligned = ((i_size == SZ_H) && i_off[0]) ||
                          ((i_size == SZ_W) && (i_off[1:0] != 2'b00));

    // Bring the addressed lane down to bit 0 before extending.
    assign w_ld_shift = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        case (i_ld_size)
            SZ_B:    o_ld_data = i_ld_signed ? XLEN'($signed(w_ld_shift[7:0]))
                                             : XLEN'(w_ld_shift[7:0]);
            SZ_H:    o_ld_data = i_ld_signed ? XLEN'($signed(w_ld_shift[15:0]))
                                             : XLEN'(w_ld_shift[15:0]);
            default: o_ld_data = i_ld_signed ? XLEN'($signed(w_ld_shift[31:0]))
                                             : XLEN'(w_ld_shift[31:0]);
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Handshaked execute stage: single-cycle integer ops, multi-cycle loads/stores
// over a req/ack data-memory port, result delivered on a valid/ready interface.
module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = OP_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              out_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_be,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int OFF_W = $clog2(XLEN/8);
    localparam int BE_W  = XLEN/8;

    state_t           r_state;
    logic             r_out_valid, r_err, r_req, r_we, r_ld_signed;
    logic [XLEN-1:0]  r_result, r_addr, r_wdata;
    logic [BE_W-1:0]  r_be;
    mem_size_t        r_ld_size;
    logic [OFF_W-1:0] r_ld_off;

    logic             w_accept, w_onehot, w_illegal, w_is_load, w_is_store, w_is_mem;
    logic             w_ld_signed, w_misaligned;
    mem_size_t        w_size;
    logic [XLEN-1:0]  w_addr, w_wdata, w_ld_data, w_alu;
    logic [BE_W-1:0]  w_be;
    logic [SH_W-1:0]  w_sh_r, w_sh_i;

    assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept = in_valid & in_ready;

    assign w_onehot   = (op != '0) && ((op & (op - OP_W'(1))) == '0);
    assign w_illegal  = !w_onehot || (|(op & ILLEGAL_MASK));
    assign w_is_load  = |op[OP_LHU:OP_LB];
    assign w_is_store = |op[OP_SW:OP_SB];
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_ld_signed = op[OP_LB] | op[OP_LH] | op[OP_LW];
    assign w_addr     = rs1 + imm;

    always_comb begin
        w_size = SZ_W;
        if (op[OP_LB] | op[OP_LBU] | op[OP_SB])
            w_size = SZ_B;
        else if (op[OP_LH] | op[OP_LHU] | op[OP_SH])
            w_size = SZ_H;
    end

    lsu_lane #(.XLEN(XLEN)) u_lsu_lane (
        .i_size       (w_size),
        .i_off        (w_addr[OFF_W-1:0]),
        .i_rs2        (rs2),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .i_ld_size    (r_ld_size),
        .i_ld_signed  (r_ld_signed),
        .i_ld_off     (r_ld_off),
        .i_rdata      (dmem_rdata),
        .o_ld_data    (w_ld_data)
    );

    assign w_sh_r = rs2[SH_W-1:0];
    assign w_sh_i = imm[SH_W-1:0];

    always_comb begin
        w_alu = '0;
        if      (op[OP_ADD])   w_alu = rs1 + rs2;
        else if (op[OP_SUB])   w_alu = rs1 - rs2;
        else if (op[OP_XOR])   w_alu = rs1 ^ rs2;
        else if (op[OP_OR])    w_alu = rs1 | rs2;
        else if (op[OP_AND])   w_alu = rs1 & rs2;
        else if (op[OP_SLL])   w_alu = rs1 << w_sh_r;
        else if (op[OP_SRL])   w_alu = rs1 >> w_sh_r;
        else if (op[OP_SRA])   w_alu = $signed(rs1) >>> w_sh_r;
        else if (op[OP_SLT])   w_alu = XLEN'($signed(rs1) < $signed(rs2));
        else if (op[OP_SLTU])  w_alu = XLEN'(rs1 < rs2);
        else if (op[OP_ADDI])  w_alu = rs1 + imm;
        else if (op[OP_XORI])  w_alu = rs1 ^ imm;
        else if (op[OP_ORI])   w_alu = rs1 | imm;
        else if (op[OP_ANDI])  w_alu = rs1 & imm;
        else if (op[OP_SLLI])  w_alu = rs1 << w_sh_i;
        else if (op[OP_SRLI])  w_alu = rs1 >> w_sh_i;
        else if (op[OP_SRAI])  w_alu = $signed(rs1) >>> w_sh_i;
        else if (op[OP_SLTI])  w_alu = XLEN'($signed(rs1) < $signed(imm));
        else if (op[OP_SLTIU]) w_alu = XLEN'(rs1 < imm);
        else if (op[OP_LUI])   w_alu = imm << 12;
        else if (op[OP_AUIPC]) w_alu = pc + (imm << 12);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_ld_size   <= SZ_W;
            r_ld_signed <= 1'b0;
            r_ld_off    <= '0;
        end else if (w_accept) begin
            r_result    <= '0;
            r_err       <= 1'b0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
            if (w_illegal || (w_is_mem && w_misaligned)) begin
                r_err <= 1'b1;
            end else if (w_is_mem) begin
                r_out_valid <= 1'b0;
                r_state     <= MEM;
                r_req       <= 1'b1;
                r_we        <= w_is_store;
                r_addr      <= w_addr;
                r_wdata     <= w_is_store ? w_wdata : '0;
                r_be        <= w_be;
                r_ld_size   <= w_size;
                r_ld_signed <= w_ld_signed;
                r_ld_off    <= w_addr[OFF_W-1:0];
            end else begin
                r_result <= w_alu;
            end
        end else begin
            case (r_state)
                MEM: if (dmem_ack) begin
                    r_req       <= 1'b0;
                    r_we        <= 1'b0;
                    r_addr      <= '0;
                    r_wdata     <= '0;
                    r_be        <= '0;
                    r_result    <= r_we ? '0 : w_ld_data;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_result    <= '0;
                    r_err       <= 1'b0;
                    r_state     <= IDLE;
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign out_err    = r_err;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit (XLEN=32): ALU ops, loads/stores, errors,
// backpressure and reset during a memory transaction.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [36:0] op;
    logic [31:0] rs1, rs2, imm, pc, result;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int n_chk  = 0;
    int n_pass = 0;

    exec_unit #(.XLEN(32), .OP_W(37)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .pc         (pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .out_err    (out_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] opb(input int b);
        logic [36:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue(input logic [36:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        op = o; rs1 = a; rs2 = b; imm = im;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        op = '0;
    endtask

    task automatic alu(input string tag, input int bitn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] exp);
        issue(opb(bitn), a, b, im);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_result"}, result, exp);
        check({tag, "_err"}, out_err, 0);
        tick;
    endtask

    task automatic memld(input string tag, input int bitn, input logic [31:0] a,
                         input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
        issue(opb(bitn), a, 32'h0, 32'h0);
        check({tag, "_req"}, dmem_req, 1);
        check({tag, "_we"}, dmem_we, 0);
        check({tag, "_be"}, dmem_be, be);
        dmem_rdata = rd;
        dmem_ack   = 1'b1;
        tick;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_result"}, result, exp);
        check({tag, "_err"}, out_err, 0);
        tick;
    endtask

    task automatic errop(input string tag, input logic [36:0] o, input logic [31:0] a);
        issue(o, a, 32'h0, 32'h0);
        check({tag, "_req"}, dmem_req, 0);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_err"}, out_err, 1);
        check({tag, "_result"}, result, 0);
        tick;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0;
        rs1 = '0; rs2 = '0; imm = '0; pc = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_err", out_err, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_be", dmem_be, 0);
        rst_n = 1'b1;
        tick;

        alu("sub",   1,  32'd5,        32'd7,  32'd0,        32'hFFFFFFFE);
        check("sub_drain", out_valid, 0);
        alu("sra",   7,  32'h80000000, 32'h24, 32'd0,        32'hF8000000);
        alu("srl",   6,  32'h80000000, 32'h24, 32'd0,        32'h08000000);
        alu("slt",   8,  32'hFFFFFFFF, 32'd1,  32'd0,        32'd1);
        alu("sltu",  9,  32'hFFFFFFFF, 32'd1,  32'd0,        32'd0);
        alu("addi",  10, 32'd10,       32'd0,  32'hFFFFFFFD, 32'd7);
        alu("srai",  16, 32'h80000000, 32'd0,  32'h21,       32'hC0000000);
        alu("lui",   35, 32'd0,        32'd0,  32'h12345,    32'h12345000);
        pc = 32'h1000;
        alu("auipc", 36, 32'd0,        32'd0,  32'd1,        32'h00002000);
        alu("and",   4,  32'hF0F0,     32'hFF00, 32'd0,      32'h0000F000);
        alu("sll",   5,  32'd1,        32'h3F, 32'd0,        32'h80000000);
        alu("sltiu", 18, 32'd3,        32'd0,  32'hFFFFFFFF, 32'd1);

        // Back-to-back ALU ops through DONE with out_ready high
        op = opb(0); rs1 = 32'd1; rs2 = 32'd2; in_valid = 1'b1;
        tick;
        check("b2b_first", result, 3);
        check("b2b_ready", in_ready, 1);
        op = opb(2); rs1 = 32'hF0; rs2 = 32'hFF;
        tick;
        in_valid = 1'b0; op = '0;
        check("b2b_valid", out_valid, 1);
        check("b2b_second", result, 32'h0F);
        tick;
        check("b2b_drain", out_valid, 0);

        // Store byte with a 3-cycle request
        issue(opb(24), 32'h100, 32'hAB, 32'd3);
        check("sb_req", dmem_req, 1);
        check("sb_we", dmem_we, 1);
        check("sb_addr", dmem_addr, 32'h103);
        check("sb_be", dmem_be, 4'b1000);
        check("sb_wdata", dmem_wdata, 32'hABABABAB);
        check("sb_valid_early", out_valid, 0);
        tick;
        check("sb_hold_req", dmem_req, 1);
        check("sb_hold_addr", dmem_addr, 32'h103);
        tick;
        dmem_ack = 1'b1;
        check("sb_req3", dmem_req, 1);
        tick;
        dmem_ack = 1'b0;
        check("sb_done_valid", out_valid, 1);
        check("sb_result", result, 0);
        check("sb_err", out_err, 0);
        check("sb_req_drop", dmem_req, 0);
        check("sb_be_clr", dmem_be, 0);
        tick;

        memld("lh",  20, 32'h102, 32'h80010000, 4'b1100, 32'hFFFF8001);
        memld("lhu", 23, 32'h102, 32'h80010000, 4'b1100, 32'h00008001);
        memld("lb",  19, 32'h103, 32'h80010000, 4'b1000, 32'hFFFFFF80);
        memld("lbu", 22, 32'h101, 32'h00007F00, 4'b0010, 32'h0000007F);
        memld("lw",  21, 32'h104, 32'h12345678, 4'b1111, 32'h12345678);

        errop("lw_mis",  opb(21), 32'h101);
        errop("sh_mis",  opb(25), 32'h103);
        errop("multi",   37'h3,   32'h0);
        errop("branch",  opb(30), 32'h0);
        errop("zero",    37'h0,   32'h0);

        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        check("stray_ack_valid", out_valid, 0);
        check("stray_ack_req", dmem_req, 0);

        // Backpressure with a second op waiting
        out_ready = 1'b0;
        issue(opb(0), 32'd3, 32'd4, 32'd0);
        check("bp_valid", out_valid, 1);
        check("bp_result", result, 7);
        op = opb(1); rs1 = 32'd10; rs2 = 32'd4; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_result", result, 7);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick;
        in_valid = 1'b0; op = '0;
        check("bp_second_valid", out_valid, 1);
        check("bp_second_result", result, 6);
        tick;
        check("bp_drain", out_valid, 0);

        // Reset while a load is outstanding
        issue(opb(21), 32'h200, 32'h0, 32'h0);
        check("rm_req", dmem_req, 1);
        tick;
        check("rm_req_hold", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_req_async", dmem_req, 0);
        check("rm_valid", out_valid, 0);
        check("rm_addr", dmem_addr, 0);
        check("rm_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        tick;
        check("rm_discard", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, handshaked execute stage that replaces the single-cycle ALU. Takes one decoded one-hot operation with operands from the decode/regfile stage, computes integer results in one cycle, and runs loads/stores as a multi-cycle request/acknowledge transaction to data memory with byte enables, sign/zero extension and misalignment detection. The result goes to writeback over a valid/ready handshake.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- OP_W, 37: width of the one-hot operation bus; bit positions come from the shared package.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation and operands are valid.
- in_ready  out  1  unit accepts the operation this cycle.
- op  in  OP_W  one-hot operation.
- rs1, rs2, imm, pc  in  XLEN each  operands; imm arrives already sign-extended by decode.
- out_valid  out  1  result is valid.
- out_ready  in  1  writeback accepts the result.
- result  out  XLEN  operation result; 0 for stores and errors.
- out_err  out  1  illegal op or misaligned access; qualified by out_valid.
- dmem_req  out  1  memory request, held until acknowledged.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  byte address, rs1+imm.
- dmem_wdata  out  XLEN  store data, replicated into the addressed lane.
- dmem_be  out  XLEN/8  byte enables.
- dmem_rdata  in  XLEN  load data; valid in the dmem_ack cycle.
- dmem_ack  in  1  memory completes the request.

## Operation
- States and transitions:
  - IDLE: on accept, ALU/illegal/misaligned ops go to DONE and legal memory ops go to MEM.
  - MEM: dmem_req=1 and request fields are stable; on dmem_ack the result is captured and the state goes to DONE.
  - DONE: out_valid=1 and result/out_err are stable; on out_ready the state goes to IDLE, or accepts the next op directly.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept happens when in_valid & in_ready.
- Op bits:
  - Register ops: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
  - Immediate ops: 10 addi, 11 xori, 12 ori, 13 andi, 14 slli, 15 srli, 16 srai, 17 slti, 18 sltiu.
  - Loads: 19 lb, 20 lh, 21 lw, 22 lbu, 23 lhu.
  - Stores: 24 sb, 25 sh, 26 sw.
  - Upper-immediate ops: 35 lui (imm<<12), 36 auipc (pc+(imm<<12)).
  - Bits 27–34 belong to the branch unit.
- Illegal op: zero bits set, more than one bit set, or any bit 27–34 set. Result is out_err=1, result=0, no memory access.
- Shift amount is the low $clog2(XLEN) bits of rs2 or imm; sra/srai are arithmetic.
- slt/slti compare signed; sltu/sltiu compare unsigned. The result is 1 or 0, zero-extended.
- All arithmetic is modulo 2^XLEN.
- Loads:
  - Lane is selected by addr[$clog2(XLEN/8)-1:0].
  - lb/lh/lw sign-extend; lbu/lhu zero-extend.
  - With XLEN=64, lw sign-extends to 64 bits.
- Stores:
  - dmem_be covers the addressed bytes only: 1 bit for sb, 2 for sh, 4 for sw.
  - wdata replicates rs2[7:0], rs2[15:0] or rs2[31:0] across the word.
- Misaligned: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0. No dmem_req is issued; out_err=1.

## Timing
- Reset values: state IDLE, in_ready=1, and every other output 0 (out_valid, result, out_err, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be).
- ALU and error ops: accepted in cycle N, out_valid in N+1.
- Memory ops:
  - Accepted in cycle N; dmem_req from N+1.
  - Ack in cycle M (M≥N+1, zero-wait allowed); out_valid in M+1.
  - dmem_req drops in M+1.
- dmem_* outputs are registered and hold while dmem_req=1 and dmem_ack=0. They are 0 when dmem_req=0.
- Backpressure: result and out_err stay stable while out_valid & !out_ready. A DONE cycle with out_ready=1 and a new accept sustains one op per cycle for ALU ops.
- Reset mid-transaction: dmem_req deasserts immediately and asynchronously. The op is discarded, and memory must tolerate the abandoned request.
- dmem_ack outside the MEM state is ignored.

## Structure
- Package exec_pkg holds:
  - OP_* bit-index localparams.
  - Illegal-mask localparam (bits 27–34).
  - State enum IDLE/MEM/DONE.
- Sub-module lsu_lane: combinational byte-enable/wdata generation, load extraction/extension, and misalignment check, parametrised by XLEN.

## Test plan
- XLEN=32, op=sub, rs1=5, rs2=7, out_ready=1 -> out_valid one cycle after accept, result=0xFFFFFFFE, out_err=0.
- op=sra, rs1=0x80000000, rs2=0x24 (shamt 4) -> result=0xF8000000. Same inputs with srl -> result=0x08000000.
- op=sb, rs1=0x100, imm=3, rs2=0xAB, dmem_ack after 3 cycles -> dmem_addr=0x103, be=4'b1000, wdata=0xABABABAB. Request held 3 cycles; out_valid the cycle after ack with result=0.
- op=lh, addr=0x102, dmem_rdata=0x8001_0000 -> result=0xFFFF8001. Same with lhu -> result=0x00008001.
- op=lw, addr=0x101 -> no dmem_req, out_err=1 next cycle. op with bits 0 and 1 both set -> out_err=1, result=0.
- Hold out_ready=0 for 4 cycles with a second op pending -> result stable and in_ready=0. Assert rst_n=0 during MEM -> dmem_req and out_valid are 0 immediately.
